controle_vedacao: RTL and testbench

CONTROLE_VEDACAO -- requirements
Module: controle_vedacao

---
 rtl/controle_vedacao.sv | 187 ++++++++++++++++++
 tb/tb_controle_vedacao.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_vedacao.sv
// ---------------------------------------------------------------------------
// controle_vedacao -- corking station sequencer for a bottling line.
//
// Stops the conveyor when a bottle reaches the corking position, requests one
// cork from the cork counter, drives the piston for T_PISTAO cycles, counts
// the sealed bottle and releases it. If no cork is available, it waits up to
// T_ESPERA_MAX cycles before latching a no-cork alarm that the operator must
// acknowledge.
//
// Parameters
//   T_PISTAO      piston actuation time in clock cycles (1..15)
//   T_ESPERA_MAX  cycles to wait for a cork before the alarm (1..15)
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous reset, active low
//   habilita          line enable (only gates leaving IDLE and the IDLE motor)
//   sensor_garrafa    bottle present at corking position
//   rolha_disponivel  cork counter has at least one cork
//   limpa_erro        operator acknowledge of the no-cork alarm
//   dec               one-cycle cork consume request
//   pistao            corking piston drive
//   motor_esteira     conveyor motor drive
//   garrafa_vedada    one-cycle pulse per sealed bottle
//   erro_sem_rolha    no-cork alarm
//   vedadas           sealed bottle count, saturates at 255
//   estado            current state code (debug)
// ---------------------------------------------------------------------------
module controle_vedacao #(
  parameter int unsigned T_PISTAO     = 4,
  parameter int unsigned T_ESPERA_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilita,
  input  logic       sensor_garrafa,
  input  logic       rolha_disponivel,
  input  logic       limpa_erro,
  output logic       dec,
  output logic       pistao,
  output logic       motor_esteira,
  output logic       garrafa_vedada,
  output logic       erro_sem_rolha,
  output logic [7:0] vedadas,
  output logic [2:0] estado
);

  // State codes are visible on estado, so their values are fixed.
  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StPosiciona = 3'd1;
  localparam logic [2:0] StPedeRolha = 3'd2;
  localparam logic [2:0] StVeda      = 3'd3;
  localparam logic [2:0] StLibera    = 3'd4;
  localparam logic [2:0] StFalta     = 3'd5;
  localparam logic [2:0] StErro      = 3'd6;

  // Terminal timer values; both parameters are limited to 1..15 so they fit.
  localparam logic [3:0] PistaoLast = 4'(T_PISTAO - 1);
  localparam logic [3:0] EsperaLast = 4'(T_ESPERA_MAX - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [7:0] vedadas_q, vedadas_d;
  logic       garrafa_q, garrafa_d;
  logic       sela;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sela    = 1'b0;

    case (state_q)
      StIdle: begin
        if (habilita && sensor_garrafa) begin
          state_d = StPosiciona;
        end
      end

      StPosiciona: begin
        if (rolha_disponivel) begin
          state_d = StPedeRolha;
        end else begin
          state_d = StFalta;
          timer_d = 4'd0;
        end
      end

      StPedeRolha: begin
        state_d = StVeda;
        timer_d = 4'd0;
      end

      StVeda: begin
        if (timer_q == PistaoLast) begin
          state_d = StLibera;
          timer_d = 4'd0;
          sela    = 1'b1;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end

      // Leave only once the bottle has cleared the sensor, so the same bottle
      // cannot be seen again from IDLE and corked twice.
      StLibera: begin
        if (!sensor_garrafa) begin
          state_d = StIdle;
        end
      end

      StFalta: begin
        if (rolha_disponivel) begin
          state_d = StPedeRolha;
        end else if (timer_q == EsperaLast) begin
          state_d = StErro;
          timer_d = 4'd0;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end

      // After acknowledge, go back through POSICIONA so the cork is re-checked
      // rather than blindly requested.
      StErro: begin
        if (limpa_erro) begin
          state_d = StPosiciona;
          timer_d = 4'd0;
        end
      end

      // Unused code 7 falls back to IDLE.
      default: begin
        state_d = StIdle;
        timer_d = 4'd0;
      end
    endcase
  end

  // Sealed-bottle counter saturates instead of wrapping.
  always_comb begin
    vedadas_d = vedadas_q;
    if (sela && (vedadas_q != 8'hFF)) begin
      vedadas_d = vedadas_q + 8'd1;
    end
  end

  // Pulse is registered so it lines up with the first LIBERA cycle.
  always_comb begin
    garrafa_d = sela;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= 4'd0;
      vedadas_q <= 8'd0;
      garrafa_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      vedadas_q <= vedadas_d;
      garrafa_q <= garrafa_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from the state register only. The single input path is
  // habilita to the motor in IDLE; reset gates it so the conveyor is held off
  // while reset is asserted even though the state reads IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    dec            = (state_q == StPedeRolha);
    pistao         = (state_q == StVeda);
    erro_sem_rolha = (state_q == StErro);
    motor_esteira  = (state_q == StLibera) || ((state_q == StIdle) && habilita && reset);
    garrafa_vedada = garrafa_q;
    vedadas        = vedadas_q;
    estado         = state_q;
  end

endmodule

// File: tb/tb_controle_vedacao.sv
module tb_controle_vedacao;

  logic       clk;
  logic       reset;
  logic       habilita;
  logic       sensor_garrafa;
  logic       rolha_disponivel;
  logic       limpa_erro;
  logic       dec;
  logic       pistao;
  logic       motor_esteira;
  logic       garrafa_vedada;
  logic       erro_sem_rolha;
  logic [7:0] vedadas;
  logic [2:0] estado;

  int total = 0;
  int bad   = 0;

  controle_vedacao #(
    .T_PISTAO    (4),
    .T_ESPERA_MAX(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .habilita        (habilita),
    .sensor_garrafa  (sensor_garrafa),
    .rolha_disponivel(rolha_disponivel),
    .limpa_erro      (limpa_erro),
    .dec             (dec),
    .pistao          (pistao),
    .motor_esteira   (motor_esteira),
    .garrafa_vedada  (garrafa_vedada),
    .erro_sem_rolha  (erro_sem_rolha),
    .vedadas         (vedadas),
    .estado          (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one bottle through without detailed checks (used for preloading).
  task automatic seal_quick();
    int k;
    k = 0;
    sensor_garrafa = 1'b1;
    while (estado !== 3'd4 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (estado !== 3'd4) begin
      bad++;
      $display("FAIL seal_quick_timeout estado=%0d exp=4", estado);
    end
    sensor_garrafa = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; habilita = 1'b1; sensor_garrafa = 1'b1;
    rolha_disponivel = 1'b1; limpa_erro = 1'b0;
    #1 reset = 1'b0;
    step();
    step();
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    total++; if (motor_esteira !== 1'b0) begin bad++; $display("FAIL reset_motor got=%0b exp=0", motor_esteira); end
    total++; if (vedadas !== 8'd0) begin bad++; $display("FAIL reset_vedadas got=%0d exp=0", vedadas); end
    total++;
    if ({dec, pistao, garrafa_vedada, erro_sem_rolha} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=0000", {dec, pistao, garrafa_vedada, erro_sem_rolha});
    end
    sensor_garrafa = 1'b0;
    reset = 1'b1;
    step();
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL release_estado got=%0d exp=0", estado); end
    total++; if (motor_esteira !== 1'b1) begin bad++; $display("FAIL idle_motor got=%0b exp=1", motor_esteira); end
  endtask

  task automatic test_normal();
    logic [2:0] exp_st [7];
    int n_dec, n_pis, n_gv;
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    n_dec = 0; n_pis = 0; n_gv = 0;
    habilita = 1'b1; rolha_disponivel = 1'b1; sensor_garrafa = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (estado !== exp_st[i]) begin
        bad++; $display("FAIL normal_seq[%0d] got=%0d exp=%0d", i, estado, exp_st[i]);
      end
      n_dec += int'(dec);
      n_pis += int'(pistao);
      n_gv  += int'(garrafa_vedada);
    end
    total++; if (n_dec != 1) begin bad++; $display("FAIL normal_dec_cycles got=%0d exp=1", n_dec); end
    total++; if (n_pis != 4) begin bad++; $display("FAIL normal_pistao_cycles got=%0d exp=4", n_pis); end
    total++; if (n_gv != 1) begin bad++; $display("FAIL normal_gv_cycles got=%0d exp=1", n_gv); end
    total++; if (vedadas !== 8'd1) begin bad++; $display("FAIL normal_vedadas got=%0d exp=1", vedadas); end
    total++; if (motor_esteira !== 1'b1) begin bad++; $display("FAIL libera_motor got=%0b exp=1", motor_esteira); end
    step();
    total++; if (estado !== 3'd4) begin bad++; $display("FAIL libera_hold got=%0d exp=4", estado); end
    total++; if (garrafa_vedada !== 1'b0) begin bad++; $display("FAIL gv_one_cycle got=%0b exp=0", garrafa_vedada); end
    sensor_garrafa = 1'b0;
    step();
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL normal_back_idle got=%0d exp=0", estado); end
  endtask

  task automatic test_falta_erro();
    int k;
    rolha_disponivel = 1'b0; sensor_garrafa = 1'b1;
    step();
    total++; if (estado !== 3'd1) begin bad++; $display("FAIL falta_pos got=%0d exp=1", estado); end
    total++; if (motor_esteira !== 1'b0) begin bad++; $display("FAIL pos_motor got=%0b exp=0", motor_esteira); end
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (estado !== 3'd5 || erro_sem_rolha !== 1'b0) begin
        bad++; $display("FAIL falta_wait[%0d] estado=%0d erro=%0b exp=5/0", i, estado, erro_sem_rolha);
      end
      step();
    end
    total++; if (estado !== 3'd6) begin bad++; $display("FAIL erro_state got=%0d exp=6", estado); end
    total++;
    if ({erro_sem_rolha, motor_esteira, dec} !== 3'b100) begin
      bad++; $display("FAIL erro_outs got=%b exp=100", {erro_sem_rolha, motor_esteira, dec});
    end
    step();
    total++; if (estado !== 3'd6) begin bad++; $display("FAIL erro_latched got=%0d exp=6", estado); end
    rolha_disponivel = 1'b1; limpa_erro = 1'b1;
    step();
    limpa_erro = 1'b0;
    total++; if (estado !== 3'd1) begin bad++; $display("FAIL erro_clear got=%0d exp=1", estado); end
    step();
    total++; if (estado !== 3'd2 || dec !== 1'b1) begin bad++; $display("FAIL erro_recheck estado=%0d dec=%0b exp=2/1", estado, dec); end
    k = 0;
    while (estado !== 3'd4 && k < 10) begin step(); k++; end
    total++; if (estado !== 3'd4 || vedadas !== 8'd2) begin bad++; $display("FAIL erro_seal estado=%0d vedadas=%0d exp=4/2", estado, vedadas); end
    sensor_garrafa = 1'b0;
    step();
  endtask

  task automatic test_falta_recover();
    int k;
    rolha_disponivel = 1'b0; sensor_garrafa = 1'b1;
    step();                    // POSICIONA
    step(); step(); step();    // FALTA wait cycles 0..2
    step();                    // wait cycle 3
    total++; if (estado !== 3'd5) begin bad++; $display("FAIL recover_falta got=%0d exp=5", estado); end
    rolha_disponivel = 1'b1;
    step();
    total++; if (estado !== 3'd2) begin bad++; $display("FAIL recover_pede got=%0d exp=2", estado); end
    total++; if (erro_sem_rolha !== 1'b0) begin bad++; $display("FAIL recover_no_erro got=%0b exp=0", erro_sem_rolha); end
    k = 0;
    while (estado !== 3'd4 && k < 10) begin step(); k++; end
    total++; if (vedadas !== 8'd3) begin bad++; $display("FAIL recover_vedadas got=%0d exp=3", vedadas); end
    sensor_garrafa = 1'b0;
    step();
  endtask

  task automatic test_hold();
    int k, n_dec, n_bad;
    rolha_disponivel = 1'b1; sensor_garrafa = 1'b1;
    k = 0;
    while (estado !== 3'd4 && k < 10) begin step(); k++; end
    total++; if (estado !== 3'd4) begin bad++; $display("FAIL hold_reach got=%0d exp=4", estado); end
    n_dec = 0; n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_dec += int'(dec);
      if (estado !== 3'd4 || motor_esteira !== 1'b1) n_bad++;
    end
    total++; if (n_bad != 0) begin bad++; $display("FAIL hold_libera cycles_off=%0d exp=0", n_bad); end
    total++; if (n_dec != 0) begin bad++; $display("FAIL hold_no_dec got=%0d exp=0", n_dec); end
    total++; if (vedadas !== 8'd4) begin bad++; $display("FAIL hold_vedadas got=%0d exp=4", vedadas); end
    sensor_garrafa = 1'b0;
    step();
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL hold_idle got=%0d exp=0", estado); end
  endtask

  task automatic test_habilita_drop();
    habilita = 1'b1; rolha_disponivel = 1'b1; sensor_garrafa = 1'b1;
    step(); step(); step();
    total++; if (estado !== 3'd3) begin bad++; $display("FAIL drop_veda got=%0d exp=3", estado); end
    habilita = 1'b0; sensor_garrafa = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (estado !== 3'd3 || pistao !== 1'b1) begin
        bad++; $display("FAIL drop_veda[%0d] estado=%0d pistao=%0b exp=3/1", i, estado, pistao);
      end
    end
    step();
    total++;
    if (estado !== 3'd4 || motor_esteira !== 1'b1 || garrafa_vedada !== 1'b1) begin
      bad++; $display("FAIL drop_libera estado=%0d motor=%0b gv=%0b exp=4/1/1", estado, motor_esteira, garrafa_vedada);
    end
    step();
    total++; if (estado !== 3'd0 || motor_esteira !== 1'b0) begin bad++; $display("FAIL drop_idle estado=%0d motor=%0b exp=0/0", estado, motor_esteira); end
    sensor_garrafa = 1'b1;
    step(); step();
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL drop_hold_idle got=%0d exp=0", estado); end
    total++; if (vedadas !== 8'd5) begin bad++; $display("FAIL drop_vedadas got=%0d exp=5", vedadas); end
    sensor_garrafa = 1'b0; habilita = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    habilita = 1'b1; rolha_disponivel = 1'b1; sensor_garrafa = 1'b1;
    step(); step(); step(); step();   // 2nd VEDA cycle
    total++; if (pistao !== 1'b1 || estado !== 3'd3) begin bad++; $display("FAIL mid_pre estado=%0d pistao=%0b exp=3/1", estado, pistao); end
    #2 reset = 1'b0;
    #1;
    total++; if (pistao !== 1'b0) begin bad++; $display("FAIL mid_pistao got=%0b exp=0", pistao); end
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL mid_estado got=%0d exp=0", estado); end
    total++; if (vedadas !== 8'd0) begin bad++; $display("FAIL mid_vedadas got=%0d exp=0", vedadas); end
    total++;
    if ({motor_esteira, garrafa_vedada, dec} !== 3'b000) begin
      bad++; $display("FAIL mid_outs got=%b exp=000", {motor_esteira, garrafa_vedada, dec});
    end
    sensor_garrafa = 1'b0;
    step();
    reset = 1'b1;
    step();
    total++; if (estado !== 3'd0 || vedadas !== 8'd0) begin bad++; $display("FAIL mid_after estado=%0d vedadas=%0d exp=0/0", estado, vedadas); end
  endtask

  task automatic test_saturate();
    int k;
    habilita = 1'b1; rolha_disponivel = 1'b1;
    for (int i = 0; i < 255; i++) seal_quick();
    total++; if (vedadas !== 8'd255) begin bad++; $display("FAIL sat_preload got=%0d exp=255", vedadas); end
    sensor_garrafa = 1'b1;
    k = 0;
    while (estado !== 3'd4 && k < 10) begin step(); k++; end
    total++; if (garrafa_vedada !== 1'b1) begin bad++; $display("FAIL sat_pulse got=%0b exp=1", garrafa_vedada); end
    total++; if (vedadas !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", vedadas); end
    sensor_garrafa = 1'b0;
    step();
    total++; if (estado !== 3'd0 || vedadas !== 8'd255) begin bad++; $display("FAIL sat_idle estado=%0d vedadas=%0d exp=0/255", estado, vedadas); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_falta_erro();
    test_falta_recover();
    test_hold();
    test_habilita_drop();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
